alu_serial_rx: RTL and testbench

Parametrised serial frame receiver for the ALU serial protocol: deserialises 11-bit frames from `sin`, assembles N operands plus one command, checks CRC-4 and framing, and presents a decoded request on a ready/valid output. It is the front end of the next-generation ALU. It generalises the fixed two-operand, 32-bit format to N_OPERANDS x OPERAND_W, and adds error classification and output back-pressure.

---
 rtl/alu_pkg.sv | 70 +++++++
 rtl/alu_crc4_serial.sv | 37 +++
 rtl/alu_serial_rx.sv | 201 ++++++++++++++++++++
 tb/tb_alu_serial_rx.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU serial protocol (RX and TX sides).
//   operation_t   : legal ALU opcodes carried in a cmd frame
//   FRAME_*       : frame type bit values and frame length
//   CRC4_POLY     : feedback taps of the x^4+x+1 CRC
//   ERR_*         : bit positions inside err_code {overrun, op, crc, count, frame}
//   rx_state_t    : receiver FSM states
//   crc4_step     : one serial CRC-4 step
//   crc4_zero_adv : advance a CRC state over n zero bits (n <= 8)
//   op_is_legal   : opcode legality check
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CMD  = 1'b1;
    localparam int   FRAME_BITS = 11;

    localparam logic [3:0] CRC4_POLY = 4'b0011;

    localparam int ERR_W       = 5;
    localparam int ERR_FRAME   = 0;
    localparam int ERR_COUNT   = 1;
    localparam int ERR_CRC     = 2;
    localparam int ERR_OP      = 3;
    localparam int ERR_OVERRUN = 4;

    typedef enum logic [2:0] {
        RX_IDLE    = 3'd0,
        RX_TYPE    = 3'd1,
        RX_PAYLOAD = 3'd2,
        RX_STOP    = 3'd3,
        RX_RESYNC  = 3'd4
    } rx_state_t;

    function automatic logic [3:0] crc4_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
    endfunction

    // The CRC is linear: crc(A then B) = crc4_zero_adv(crc(A), |B|) ^ crc_from_zero(B).
    function automatic logic [3:0] crc4_zero_adv(input logic [3:0] c, input int n);
        logic [3:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (i < n) begin
                r = crc4_step(r, 1'b0);
            end
        end
        return r;
    endfunction

    function automatic logic op_is_legal(input logic [2:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB: ok = 1'b1;
            default:                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu_crc4_serial.sv
// -----------------------------------------------------------------------------
// alu_crc4_serial
// One-bit-per-cycle CRC-4 (x^4+x+1) LFSR, initial value 0.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (wins over en)
//   en       : fold bit d into the state this cycle
//   d        : serial data bit
//   crc      : current 4-bit state
// -----------------------------------------------------------------------------
module alu_crc4_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       d,
    output logic [3:0] crc
);
    import alu_pkg::*;

    logic [3:0] crc_r;

    // LFSR state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_r <= 4'b0000;
        end else if (clr) begin
            crc_r <= 4'b0000;
        end else if (en) begin
            crc_r <= crc4_step(crc_r, d);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign crc = crc_r;

endmodule

// File: rtl/alu_serial_rx.sv
// -----------------------------------------------------------------------------
// alu_serial_rx
// Serial frame receiver for the ALU protocol. Frames are
// {start 0, type, 8 payload bits MSB first, stop 1}. Data frames fill an
// N_OPERANDS*OPERAND_W operand buffer byte by byte; a cmd frame
// {x, op[2:0], crc[3:0]} closes the request, which is checked and then
// presented on a ready/valid output register.
//   clk, rst      : clock, asynchronous active-high reset
//   sin           : serial line, idles high, sampled every rising edge
//   out_valid     : output register holds a request
//   out_ready     : consumer accepts when out_valid && out_ready
//   out_operands  : operand 0 in the top OPERAND_W bits
//   out_op        : opcode
//   err_valid     : one-cycle pulse per faulty frame or cmd
//   err_code      : {overrun, op, crc, count, frame}
// -----------------------------------------------------------------------------
module alu_serial_rx #(
    parameter int N_OPERANDS = 2,
    parameter int OPERAND_W  = 32,
    parameter int CRC_CHECK  = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             sin,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [N_OPERANDS*OPERAND_W-1:0]  out_operands,
    output logic [2:0]                       out_op,
    output logic                             err_valid,
    output logic [4:0]                       err_code
);
    import alu_pkg::*;

    localparam int               NB           = N_OPERANDS * OPERAND_W / 8;
    localparam int               TOTAL_W      = N_OPERANDS * OPERAND_W;
    localparam int               CNT_W        = $clog2(NB + 1);
    localparam logic [CNT_W-1:0] NB_CNT       = CNT_W'(NB);
    localparam int               PAYLOAD_BITS = FRAME_BITS - 3;
    localparam logic [2:0]       LAST_BIT     = 3'(PAYLOAD_BITS - 1);

    rx_state_t          state_r;
    logic               is_cmd_r;
    logic [2:0]         bit_cnt_r;
    logic [7:0]         shreg_r;
    logic [CNT_W-1:0]   byte_cnt_r;
    logic               extra_r;
    logic [3:0]         crc_r;
    logic [TOTAL_W-1:0] buf_r;

    logic               out_valid_r;
    logic [TOTAL_W-1:0] out_operands_r;
    logic [2:0]         out_op_r;
    logic               err_valid_r;
    logic [ERR_W-1:0]   err_code_r;

    logic               lfsr_clr_s;
    logic               lfsr_en_s;
    logic               lfsr_d_s;
    logic [3:0]         lfsr_crc_s;

    logic [2:0]         cmd_op_s;
    logic [3:0]         data_crc_s;
    logic [3:0]         cmd_crc_s;
    logic               count_err_s;
    logic               op_err_s;
    logic               crc_err_s;
    logic               qualify_s;
    logic               full_s;
    logic [ERR_W-1:0]   cmd_err_code_s;

    // Per-frame CRC runs from zero and is merged into crc_r by linearity.
    // For a cmd it is fed the constant 1 in place of the ignored bit 7,
    // then op[2:0], so it ends up holding crc_from_zero({1, op}).
    always_comb begin
        lfsr_clr_s = 1'b0;
        lfsr_en_s  = 1'b0;
        lfsr_d_s   = sin;
        if (state_r == RX_TYPE) begin
            lfsr_clr_s = 1'b1;
        end else if (state_r == RX_PAYLOAD) begin
            lfsr_en_s = !is_cmd_r || (bit_cnt_r < 3'd4);
            lfsr_d_s  = (is_cmd_r && (bit_cnt_r == 3'd0)) ? 1'b1 : sin;
        end else begin
            lfsr_en_s = 1'b0;
        end
    end

    alu_crc4_serial u_crc (
        .clk (clk),
        .rst (rst),
        .clr (lfsr_clr_s),
        .en  (lfsr_en_s),
        .d   (lfsr_d_s),
        .crc (lfsr_crc_s)
    );

    // Cmd decode and error classification, evaluated at the stop bit
    always_comb begin
        cmd_op_s    = shreg_r[6:4];
        data_crc_s  = crc4_zero_adv(crc_r, 8) ^ lfsr_crc_s;
        cmd_crc_s   = crc4_zero_adv(crc_r, 4) ^ lfsr_crc_s;
        count_err_s = (byte_cnt_r != NB_CNT) || extra_r;
        op_err_s    = !op_is_legal(cmd_op_s);
        crc_err_s   = (cmd_crc_s != shreg_r[3:0]);
        qualify_s   = !count_err_s && !op_err_s && ((CRC_CHECK == 0) || !crc_err_s);
        full_s      = out_valid_r && !out_ready;
        cmd_err_code_s              = 5'b00000;
        cmd_err_code_s[ERR_OVERRUN] = qualify_s && full_s;
        cmd_err_code_s[ERR_OP]      = op_err_s;
        cmd_err_code_s[ERR_CRC]     = crc_err_s;
        cmd_err_code_s[ERR_COUNT]   = count_err_s;
        cmd_err_code_s[ERR_FRAME]   = 1'b0;
    end

    // Receiver FSM, request assembly and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= RX_IDLE;
            is_cmd_r       <= FRAME_DATA;
            bit_cnt_r      <= 3'd0;
            shreg_r        <= 8'h00;
            byte_cnt_r     <= '0;
            extra_r        <= 1'b0;
            crc_r          <= 4'b0000;
            buf_r          <= '0;
            out_valid_r    <= 1'b0;
            out_operands_r <= '0;
            out_op_r       <= 3'b000;
            err_valid_r    <= 1'b0;
            err_code_r     <= 5'b00000;
        end else begin
            err_valid_r <= 1'b0;
            err_code_r  <= 5'b00000;
            if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
            case (state_r)
                RX_IDLE: begin
                    state_r <= sin ? RX_IDLE : RX_TYPE;
                end
                RX_TYPE: begin
                    is_cmd_r  <= sin;
                    bit_cnt_r <= 3'd0;
                    state_r   <= RX_PAYLOAD;
                end
                RX_PAYLOAD: begin
                    shreg_r   <= {shreg_r[6:0], sin};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    state_r   <= (bit_cnt_r == LAST_BIT) ? RX_STOP : RX_PAYLOAD;
                end
                RX_STOP: begin
                    if (sin) begin
                        state_r <= RX_IDLE;
                        if (is_cmd_r == FRAME_CMD) begin
                            if (qualify_s && !full_s) begin
                                out_valid_r    <= 1'b1;
                                out_operands_r <= buf_r;
                                out_op_r       <= cmd_op_s;
                            end
                            err_valid_r <= |cmd_err_code_s;
                            err_code_r  <= cmd_err_code_s;
                            byte_cnt_r  <= '0;
                            extra_r     <= 1'b0;
                            crc_r       <= 4'b0000;
                        end else if (byte_cnt_r != NB_CNT) begin
                            for (int k = 0; k < NB; k++) begin
                                if (byte_cnt_r == CNT_W'(k)) begin
                                    buf_r[TOTAL_W-1-8*k -: 8] <= shreg_r;
                                end
                            end
                            byte_cnt_r <= byte_cnt_r + CNT_W'(1);
                            crc_r      <= data_crc_s;
                        end else begin
                            extra_r <= 1'b1;
                        end
                    end else begin
                        state_r               <= RX_RESYNC;
                        err_valid_r           <= 1'b1;
                        err_code_r[ERR_FRAME] <= 1'b1;
                        byte_cnt_r            <= '0;
                        extra_r               <= 1'b0;
                        crc_r                 <= 4'b0000;
                    end
                end
                RX_RESYNC: begin
                    state_r <= sin ? RX_IDLE : RX_RESYNC;
                end
                default: begin
                    state_r <= RX_IDLE;
                end
            endcase
        end
    end

    assign out_valid    = out_valid_r;
    assign out_operands = out_operands_r;
    assign out_op       = out_op_r;
    assign err_valid    = err_valid_r;
    assign err_code     = err_code_r;

endmodule

// File: tb/tb_alu_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_rx
// Directed bench for alu_serial_rx (default geometry: 2 x 32-bit operands).
// A second instance with CRC_CHECK=0 shares the same stimulus.
// -----------------------------------------------------------------------------
module tb_alu_serial_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic        sin;
    logic        out_ready;

    logic        out_valid,    nc_out_valid;
    logic [63:0] out_operands, nc_out_operands;
    logic [2:0]  out_op,       nc_out_op;
    logic        err_valid,    nc_err_valid;
    logic [4:0]  err_code,     nc_err_code;

    int n_cmp = 0;
    int n_bad = 0;

    int         err_cnt = 0,     nc_err_cnt = 0;
    logic [4:0] err_last = 5'b0, nc_err_last = 5'b0;
    int         deliver_cnt = 0, nc_deliver_cnt = 0;

    logic [7:0] req_bytes [0:15];

    alu_serial_rx #(.N_OPERANDS(2), .OPERAND_W(32), .CRC_CHECK(1)) dut (
        .clk(clk), .rst(rst), .sin(sin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_operands(out_operands), .out_op(out_op),
        .err_valid(err_valid), .err_code(err_code)
    );

    alu_serial_rx #(.N_OPERANDS(2), .OPERAND_W(32), .CRC_CHECK(0)) dut_nc (
        .clk(clk), .rst(rst), .sin(sin),
        .out_valid(nc_out_valid), .out_ready(out_ready),
        .out_operands(nc_out_operands), .out_op(nc_out_op),
        .err_valid(nc_err_valid), .err_code(nc_err_code)
    );

    always #5 clk = ~clk;

    // Event monitor: error pulses and accepted handshakes
    always @(negedge clk) begin
        if (err_valid) begin
            err_cnt  <= err_cnt + 1;
            err_last <= err_code;
        end
        if (nc_err_valid) begin
            nc_err_cnt  <= nc_err_cnt + 1;
            nc_err_last <= nc_err_code;
        end
        if (out_valid && out_ready)       deliver_cnt    <= deliver_cnt + 1;
        if (nc_out_valid && out_ready)    nc_deliver_cnt <= nc_deliver_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic d);
        logic fb;
        fb = c[3] ^ d;
        return {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
    endfunction

    // Reference CRC over 8 request bytes, the constant 1, then op
    function automatic logic [7:0] make_cmd(input logic [2:0] op);
        logic [3:0] c;
        c = 4'b0000;
        for (int i = 0; i < 8; i++)
            for (int b = 7; b >= 0; b--)
                c = crc_step(c, req_bytes[i][b]);
        c = crc_step(c, 1'b1);
        for (int b = 2; b >= 0; b--)
            c = crc_step(c, op[b]);
        return {1'b0, op, c};
    endfunction

    task automatic send_frame(input logic is_cmd, input logic [7:0] payload, input logic stop);
        sin = 1'b0;   @(negedge clk);
        sin = is_cmd; @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            sin = payload[i];
            @(negedge clk);
        end
        sin = stop;   @(negedge clk);
        sin = 1'b1;
    endtask

    task automatic send_req(input int n, input logic [7:0] cmd);
        for (int i = 0; i < n; i++) send_frame(1'b0, req_bytes[i], 1'b1);
        send_frame(1'b1, cmd, 1'b1);
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 5 && !out_valid; i++) @(negedge clk);
        check_eq(tag, out_valid, 1);
    endtask

    task automatic fill_bytes(input logic [63:0] v);
        for (int i = 0; i < 16; i++) req_bytes[i] = (i < 8) ? v[63-8*i -: 8] : 8'h00;
    endtask

    int eb, db, ncb, ndb;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sin = 1'b1; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_valid",    out_valid, 0);
        check_eq("rst_operands", out_operands, 0);
        check_eq("rst_op",       out_op, 0);
        check_eq("rst_errv",     err_valid, 0);
        check_eq("rst_errc",     err_code, 0);
        rst = 1'b0;
        idle(3);

        // AND on zero operands, crc 1011
        fill_bytes(64'h0); eb = err_cnt; db = deliver_cnt;
        send_req(8, 8'h0B);
        wait_valid("and_valid");
        check_eq("and_operands", out_operands, 64'h0);
        check_eq("and_op", out_op, 3'b000);
        idle(6);
        check_eq("and_noerr", err_cnt - eb, 0);
        check_eq("and_deliv", deliver_cnt - db, 1);

        // OR on zero operands, crc 1000
        eb = err_cnt;
        send_req(8, 8'h18);
        wait_valid("or_valid");
        check_eq("or_op", out_op, 3'b001);
        idle(6);
        check_eq("or_noerr", err_cnt - eb, 0);

        // Bad crc: rejected with CRC_CHECK=1, delivered and flagged with CRC_CHECK=0
        eb = err_cnt; db = deliver_cnt; ncb = nc_err_cnt; ndb = nc_deliver_cnt;
        send_req(8, 8'h0A);
        idle(8);
        check_eq("crc_errcnt",    err_cnt - eb, 1);
        check_eq("crc_errcode",   err_last, 5'b00100);
        check_eq("crc_nodeliv",   deliver_cnt - db, 0);
        check_eq("nc_crc_deliv",  nc_deliver_cnt - ndb, 1);
        check_eq("nc_crc_errcnt", nc_err_cnt - ncb, 1);
        check_eq("nc_crc_code",   nc_err_last, 5'b00100);

        // Non-zero operands, ADD
        fill_bytes(64'h0102030405060708); eb = err_cnt;
        send_req(8, make_cmd(3'b100));
        wait_valid("add_valid");
        check_eq("add_operands", out_operands, 64'h0102030405060708);
        check_eq("add_op", out_op, 3'b100);
        idle(6);
        check_eq("add_noerr", err_cnt - eb, 0);

        // Framing error on the third data frame, line held low for a while
        fill_bytes(64'h0); eb = err_cnt; db = deliver_cnt;
        send_frame(1'b0, 8'h00, 1'b1);
        send_frame(1'b0, 8'h00, 1'b1);
        send_frame(1'b0, 8'h00, 1'b0);
        sin = 1'b0; repeat (5) @(negedge clk);
        idle(4);
        check_eq("frm_errcnt",  err_cnt - eb, 1);
        check_eq("frm_errcode", err_last, 5'b00001);
        check_eq("frm_nodeliv", deliver_cnt - db, 0);

        // Recovery after resync
        fill_bytes(64'hDEADBEEF01234567); eb = err_cnt;
        send_req(8, make_cmd(3'b101));
        wait_valid("rec_valid");
        check_eq("rec_operands", out_operands, 64'hDEADBEEF01234567);
        check_eq("rec_op", out_op, 3'b101);
        idle(6);
        check_eq("rec_noerr", err_cnt - eb, 0);

        // Count errors: 7 bytes, then 9 bytes
        fill_bytes(64'h0); eb = err_cnt; db = deliver_cnt;
        send_req(7, 8'h0B);
        idle(6);
        check_eq("cnt7_errcnt",  err_cnt - eb, 1);
        check_eq("cnt7_errcode", err_last, 5'b00010);
        eb = err_cnt;
        send_req(9, 8'h0B);
        idle(6);
        check_eq("cnt9_errcnt",  err_cnt - eb, 1);
        check_eq("cnt9_errcode", err_last, 5'b00010);
        check_eq("cnt_nodeliv",  deliver_cnt - db, 0);

        // Illegal op 011 with its correct crc 1110
        eb = err_cnt; db = deliver_cnt;
        send_req(8, 8'h3E);
        idle(6);
        check_eq("op_errcnt",  err_cnt - eb, 1);
        check_eq("op_errcode", err_last, 5'b01000);
        check_eq("op_nodeliv", deliver_cnt - db, 0);

        // Back-pressure: first request held, second overruns
        out_ready = 1'b0;
        fill_bytes(64'h0102030405060708); eb = err_cnt;
        send_req(8, make_cmd(3'b100));
        wait_valid("ovr_first_valid");
        fill_bytes(64'h0);
        send_req(8, 8'h0B);
        idle(6);
        check_eq("ovr_errcnt",   err_cnt - eb, 1);
        check_eq("ovr_errcode",  err_last, 5'b10000);
        check_eq("ovr_held_v",   out_valid, 1);
        check_eq("ovr_held_ops", out_operands, 64'h0102030405060708);
        check_eq("ovr_held_op",  out_op, 3'b100);
        db = deliver_cnt;
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("ovr_accepted", out_valid, 0);
        @(negedge clk);
        check_eq("ovr_deliv", deliver_cnt - db, 1);
        idle(4);

        // Reset asserted in the middle of a payload
        out_ready = 1'b0;
        fill_bytes(64'h1122334455667788);
        send_req(8, make_cmd(3'b001));
        wait_valid("prerst_valid");
        eb = err_cnt;
        sin = 1'b0; @(negedge clk);
        sin = 1'b0; @(negedge clk);
        sin = 1'b1; @(negedge clk);
        sin = 1'b0; @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("mrst_valid",    out_valid, 0);
        check_eq("mrst_operands", out_operands, 0);
        check_eq("mrst_op",       out_op, 0);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        idle(4);
        check_eq("mrst_noerr", err_cnt - eb, 0);
        db = deliver_cnt;
        send_req(8, make_cmd(3'b001));
        wait_valid("post_valid");
        check_eq("post_operands", out_operands, 64'h1122334455667788);
        check_eq("post_op", out_op, 3'b001);
        idle(6);
        check_eq("post_deliv", deliver_cnt - db, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
